// File: rtl/mem_ldst_resp_if.sv
// Request/response bundle between the ldst execute stage (master) and the data-memory responder (slave).
interface mem_ldst_resp_if #(
  parameter int unsigned W_DATA = 32
);
  logic              req_i;
  logic [W_DATA-1:0] addr_i;
  logic              write_i;
  logic [W_DATA-1:0] data_i;
  logic              busy_o;
  logic              ack_o;
  logic              rvalid_o;
  logic [W_DATA-1:0] rdata_o;
  logic              fault_o;

  modport master (
    output req_i, addr_i, write_i, data_i,
    input  busy_o, ack_o, rvalid_o, rdata_o, fault_o
  );

  modport slave (
    input  req_i, addr_i, write_i, data_i,
    output busy_o, ack_o, rvalid_o, rdata_o, fault_o
  );
endinterface

// File: rtl/mem_ldst_resp.sv
// Data-memory responder: word RAM with a fixed multi-cycle access, ack/rvalid pulses back to writeback.
// Optional out-of-range detection on upper address bits is enabled by defining LDST_BOUNDS_CHECK_EN.
module mem_ldst_resp #(
  parameter int unsigned W_DATA      = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_ldst_resp_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [W_DATA-1:0]     data_q, data_d;
  logic                  ack_q, ack_d;
  logic                  rvalid_q, rvalid_d;
  logic [W_DATA-1:0]     rdata_q, rdata_d;
  logic                  oob_c;
  logic                  ram_we_c;

  logic [W_DATA-1:0]     mem_q [DEPTH];

`ifdef LDST_BOUNDS_CHECK_EN
  logic oob_q, oob_d;
  logic fault_q, fault_d;

  // Out-of-range is decided at acceptance so only one flag travels with the request.
  always_comb begin
    oob_d   = oob_q;
    fault_d = 1'b0;
    if (state_q == ST_IDLE && bus.req_i) begin
      oob_d = |bus.addr_i[W_DATA-1:DEPTH_LOG2];
    end
    if (state_q == ST_BUSY && cnt_q == '0) begin
      fault_d = oob_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oob_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      oob_q   <= oob_d;
      fault_q <= fault_d;
    end
  end

  assign oob_c       = oob_q;
  assign bus.fault_o = fault_q;
`else
  logic unused_addr_hi_c;

  // Upper address bits alias onto the RAM; no fault is ever raised.
  assign unused_addr_hi_c = ^bus.addr_i[W_DATA-1:DEPTH_LOG2];
  assign oob_c            = 1'b0;
  assign bus.fault_o      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_i)    state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0)  state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Datapath and response outputs
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    data_d   = data_q;
    ack_d    = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    ram_we_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          idx_d  = bus.addr_i[DEPTH_LOG2-1:0];
          wr_d   = bus.write_i;
          data_d = bus.data_i;
          cnt_d  = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          ack_d = 1'b1;
          if (wr_q) begin
            // Reset at the access edge cancels the write.
            ram_we_c = !oob_c && !rst;
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = oob_c ? '0 : mem_q[idx_q];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we_c) begin
      mem_q[idx_q] <= data_q;
    end
  end

  assign bus.busy_o   = (state_q == ST_BUSY);
  assign bus.ack_o    = ack_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;

endmodule
